// File: rtl/seq_pkg.sv
// Shared definitions for the accumulator processor control path:
// sequencer states and the opcode classes the sequencer and decoder agree on.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        MEM_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam logic [3:0] OP_STORE = 4'b0110;
    localparam logic [3:0] OP_LOAD  = 4'b0111;
    localparam logic [3:0] OP_BEQ   = 4'b1000;
    localparam logic [3:0] OP_JUMP  = 4'b1001;
    localparam logic [3:0] OP_CMP   = 4'b1010;
    localparam logic [3:0] OP_HALT  = 4'b1011;

endpackage

// File: rtl/pc_unit.sv
// Program counter register: clear to 0, step by +1 or by a sign-extended
// 5-bit offset, otherwise hold. All sums wrap modulo 2**PC_W.
module pc_unit #(
    parameter int PC_W = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            advance,
    input  logic            jump,
    input  logic [4:0]      offset,
    output logic [PC_W-1:0] pc
);

    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] pc_next;

    assign off_ext = {{(PC_W-5){offset[4]}}, offset};

    always_comb begin
        pc_next = pc;
        if (clear)
            pc_next = '0;
        else if (advance)
            pc_next = jump ? pc + off_ext : pc + PC_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= '0;
        else
            pc <= pc_next;
    end

endmodule

// File: rtl/prog_sequencer.sv
// Control FSM for the 9-bit accumulator processor: one instruction per cycle,
// stalls loads/stores on the data-memory handshake, resolves BEQ/JUMP, counts retirements.
module prog_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [8:0]       instr,
    input  logic             branch_flag,
    input  logic             dmem_ack,
    output logic [PC_W-1:0]  pc,
    output logic             rf_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] retired
);

    state_t     state;
    logic       we_q;
    logic [3:0] op;
    logic       is_store, is_load, is_mem, is_beq, is_jump, is_cmp, is_halt, is_alu;
    logic       in_exec, in_wait, start_ok;
    logic       mem_done, retire, advance, take_off;

    assign op       = instr[8:5];
    assign is_store = (op == OP_STORE);
    assign is_load  = (op == OP_LOAD);
    assign is_mem   = is_store | is_load;
    assign is_beq   = (op == OP_BEQ);
    assign is_jump  = (op == OP_JUMP);
    assign is_cmp   = (op == OP_CMP);
    assign is_halt  = (op == OP_HALT);
    assign is_alu   = ~(is_mem | is_beq | is_jump | is_cmp | is_halt);

    assign in_exec  = (state == EXEC);
    assign in_wait  = (state == MEM_WAIT);
    assign start_ok = start & ((state == IDLE) | (state == DONE));

    // Outputs decode straight from state so reset drops them asynchronously.
    assign dmem_req = (in_exec & is_mem) | in_wait;
    assign dmem_we  = in_exec ? is_store : (in_wait & we_q);
    assign mem_done = dmem_req & dmem_ack;
    assign rf_we    = (in_exec & is_alu)
                    | (((in_exec & is_load) | (in_wait & ~we_q)) & dmem_ack);

    assign retire   = (in_exec & ~is_mem) | mem_done;
    assign advance  = (in_exec & ~is_mem & ~is_halt) | mem_done;
    assign take_off = in_exec & (is_jump | (is_beq & branch_flag));

    assign busy = in_exec | in_wait;
    assign done = (state == DONE);

    pc_unit #(.PC_W(PC_W)) u_pc (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_ok),
        .advance (advance),
        .jump    (take_off),
        .offset  (instr[4:0]),
        .pc      (pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            retired <= '0;
        end else begin
            if (start_ok)
                retired <= '0;
            else if (retire && retired != {CNT_W{1'b1}})
                retired <= retired + CNT_W'(1);

            case (state)
                IDLE, DONE: begin
                    if (start) state <= EXEC;
                end
                EXEC: begin
                    if (is_halt)
                        state <= DONE;
                    else if (is_mem && !dmem_ack) begin
                        state <= MEM_WAIT;
                        we_q  <= is_store;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ack) state <= EXEC;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: ROM-driven programs with hand-computed
// pc / handshake / counter expectations.
module tb_prog_sequencer;

    localparam logic [8:0] ADDI   = 9'b0001_00001;
    localparam logic [8:0] HALT   = 9'b1011_00000;
    localparam logic [8:0] LOAD   = 9'b0111_00000;
    localparam logic [8:0] STORE  = 9'b0110_00000;
    localparam logic [3:0] OP_J   = 4'b1001;
    localparam logic [3:0] OP_B   = 4'b1000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       branch_flag = 1'b0;
    logic       dmem_ack = 1'b0;
    logic [8:0] instr;
    logic [9:0] pc;
    logic       rf_we, dmem_req, dmem_we, busy, done;
    logic [3:0] retired;
    logic [8:0] rom [0:1023];

    int compares = 0;
    int fails = 0;

    assign instr = rom[pc];
    always #5 clk = ~clk;

    prog_sequencer #(.PC_W(10), .CNT_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .instr       (instr),
        .branch_flag (branch_flag),
        .dmem_ack    (dmem_ack),
        .pc          (pc),
        .rf_we       (rf_we),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .busy        (busy),
        .done        (done),
        .retired     (retired)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compares++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = HALT;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        chk("rst_pc", 32'(pc), 0);
        chk("rst_outs", {27'd0, rf_we, dmem_req, dmem_we, busy, done}, 0);
        chk("rst_retired", 32'(retired), 0);
        reset = 1'b0;
        step();
    endtask

    task automatic go();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        clear_rom();
        step();

        // 1: ADDI, ADDI, HALT; a start pulse mid-run is ignored
        rom[0] = ADDI; rom[1] = ADDI; rom[2] = HALT;
        do_reset();
        go();
        chk("t1_pc0", 32'(pc), 0);
        chk("t1_we0", {30'd0, rf_we, busy}, 3);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("t1_pc1", 32'(pc), 1);
        chk("t1_we1", 32'(rf_we), 1);
        step();
        chk("t1_pc2", 32'(pc), 2);
        chk("t1_we2", 32'(rf_we), 0);
        step();
        chk("t1_done", {30'd0, done, busy}, 2);
        chk("t1_pc_hold", 32'(pc), 2);
        chk("t1_retired", 32'(retired), 3);

        // 2: LOAD at pc=4 acked after 3 wait cycles
        clear_rom();
        for (int i = 0; i < 4; i++) rom[i] = ADDI;
        rom[4] = LOAD;
        rom[5] = HALT;
        do_reset();
        go();
        repeat (4) step();
        chk("t2_req_exec", {29'd0, dmem_req, dmem_we, rf_we}, 3'b100);
        chk("t2_pc_exec", 32'(pc), 4);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t2_req_wait", {29'd0, dmem_req, dmem_we, rf_we}, 3'b100);
            chk("t2_pc_wait", 32'(pc), 4);
        end
        step();
        dmem_ack = 1'b1;
        #1;
        chk("t2_ack_cycle", {28'd0, dmem_req, dmem_we, rf_we, busy}, 4'b1011);
        step();
        dmem_ack = 1'b0;
        chk("t2_pc_after", 32'(pc), 5);
        chk("t2_req_after", 32'(dmem_req), 0);
        step();
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("t2_ack_in_done", {30'd0, done, dmem_req}, 2);
        chk("t2_retired", 32'(retired), 6);

        // 3: STORE acked in the same cycle
        clear_rom();
        rom[0] = STORE;
        do_reset();
        go();
        dmem_ack = 1'b1;
        #1;
        chk("t3_store", {29'd0, dmem_req, dmem_we, rf_we}, 3'b110);
        step();
        dmem_ack = 1'b0;
        chk("t3_pc", 32'(pc), 1);
        chk("t3_req_off", 32'(dmem_req), 0);

        // 4: BEQ taken/not taken and JUMP wrap both ways
        clear_rom();
        rom[0]    = {OP_J, 5'd10};
        rom[10]   = {OP_B, 5'b11101};
        rom[7]    = {OP_J, 5'd3};
        rom[11]   = {OP_J, 5'b10001};
        rom[1020] = {OP_J, 5'd15};
        do_reset();
        go();
        step();
        chk("t4_jump10", 32'(pc), 10);
        branch_flag = 1'b1;
        step();
        chk("t4_beq_taken", 32'(pc), 7);
        step();
        chk("t4_jump_back", 32'(pc), 10);
        branch_flag = 1'b0;
        step();
        chk("t4_beq_not", 32'(pc), 11);
        step();
        chk("t4_wrap_neg", 32'(pc), 1020);
        step();
        chk("t4_wrap_pos", 32'(pc), 11);

        // 5: reset during MEM_WAIT, then restart
        clear_rom();
        rom[0] = LOAD;
        do_reset();
        go();
        step();
        chk("t5_in_wait", {30'd0, dmem_req, busy}, 3);
        reset = 1'b1;
        #1;
        chk("t5_async", {29'd0, dmem_req, busy, rf_we}, 0);
        chk("t5_pc", 32'(pc), 0);
        #2;
        reset = 1'b0;
        step();
        go();
        chk("t5_restart", {21'd0, pc, dmem_req}, {21'd0, 10'd0, 1'b1});
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        chk("t5_pc_after", 32'(pc), 1);

        // 6: 20 ALU instructions saturate a 4-bit counter; re-start clears it
        clear_rom();
        for (int i = 0; i < 20; i++) rom[i] = ADDI;
        do_reset();
        go();
        repeat (10) step();
        chk("t6_ret10", 32'(retired), 10);
        repeat (10) step();
        chk("t6_pc20", 32'(pc), 20);
        chk("t6_ret_sat", 32'(retired), 15);
        step();
        chk("t6_done", {30'd0, done, busy}, 2);
        chk("t6_ret_final", 32'(retired), 15);
        go();
        chk("t6_rerun", {18'd0, pc, retired}, 0);
        chk("t6_rerun_busy", {30'd0, done, busy}, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end

endmodule
